// File: rtl/seqdec.sv
// Serial detector for the bit pattern "00001" (oldest bit first), overlapping.
// Counts consecutive zeros and saturates at four. A one that arrives while saturated pulses found_flag.
module seqdec (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       data_in,
   output logic       found_flag,
   output logic [2:0] o_dbg_state
);

   typedef enum logic [2:0] {
      Z0 = 3'd0,
      Z1 = 3'd1,
      Z2 = 3'd2,
      Z3 = 3'd3,
      Z4 = 3'd4
   } state_t;

   state_t r_state;
   logic   r_found;

   // found_flag is loaded 0 on every edge that does not complete a match.
   // This keeps it to a single-cycle pulse with no path from data_in.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state <= Z0;
         r_found <= 1'b0;
      end else begin
         r_found <= 1'b0;
         case (r_state)
            Z0: r_state <= data_in ? Z0 : Z1;
            Z1: r_state <= data_in ? Z0 : Z2;
            Z2: r_state <= data_in ? Z0 : Z3;
            Z3: r_state <= data_in ? Z0 : Z4;
            Z4: begin
               if (data_in) begin
                  r_state <= Z0;
                  r_found <= 1'b1;
               end else begin
                  r_state <= Z4;
               end
            end
            default: r_state <= Z0;
         endcase
      end
   end

   assign found_flag  = r_found;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seqdec.sv
// Directed bench for seqdec. The driver queues the expected flag and state for each edge.
// A monitor pops one entry per cycle and compares it against the DUT.
module tb_seqdec;

   logic       clock;
   logic       reset_n;
   logic       data_in;
   logic       found_flag;
   logic [2:0] o_dbg_state;

   localparam logic [2:0] S_Z0 = 3'd0;
   localparam logic [2:0] S_Z4 = 3'd4;

   // entry = {check_state, expected_state[2:0], expected_flag}
   logic [4:0] exp_q[$];
   int         total = 0;
   int         bad   = 0;

   seqdec dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .data_in     (data_in),
      .found_flag  (found_flag),
      .o_dbg_state (o_dbg_state)
   );

   // clock / reset
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      reset_n = 1'b0;
      data_in = 1'b0;
   end

   // driver tasks: inputs change on the falling edge, and the expectation applies after the next rising edge
   task automatic drive(input logic rst_n, input logic d, input logic e_flag,
                        input logic chk, input logic [2:0] e_st);
      @(negedge clock);
      reset_n = rst_n;
      data_in = d;
      exp_q.push_back({chk, e_st, e_flag});
   endtask

   task automatic do_reset(input int cycles);
      for (int i = 0; i < cycles; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, S_Z0);
   endtask

   // bits and exp are read MSB-first over the lowest n positions
   task automatic run_seq(input logic [31:0] bits, input logic [31:0] exp, input int n);
      for (int i = n - 1; i >= 0; i--) drive(1'b1, bits[i], exp[i], 1'b0, S_Z0);
   endtask

   // scoreboard monitor
   initial begin
      logic [4:0] e;
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (found_flag !== e[0]) begin
               bad++;
               $display("FAIL flag t=%0t actual=%b required=%b", $time, found_flag, e[0]);
            end
            if (e[4]) begin
               total++;
               if (o_dbg_state !== e[3:1]) begin
                  bad++;
                  $display("FAIL state t=%0t actual=%0d required=%0d", $time, o_dbg_state, e[3:1]);
               end
            end
         end
      end
   end

   initial begin
      int wait_cycles;
      // basic detection, then the flag drops again
      do_reset(2);
      run_seq(32'b000010, 32'b000010, 6);

      // no match anywhere in a mixed stream
      do_reset(1);
      run_seq(32'b011101100110111010, 32'b0, 18);

      // long zero run still gives a single detection
      do_reset(1);
      run_seq(32'b00000001, 32'b00000001, 8);

      // back-to-back detections
      do_reset(1);
      run_seq(32'b0000100001, 32'b0000100001, 10);

      // reset mid-sequence discards the zero history
      run_seq(32'b000, 32'b000, 3);
      drive(1'b0, 1'b0, 1'b0, 1'b1, S_Z0);
      run_seq(32'b01, 32'b00, 2);
      run_seq(32'b00001, 32'b00001, 5);

      // reset wins on the edge that would complete a detection
      run_seq(32'b000, 32'b000, 3);
      drive(1'b1, 1'b0, 1'b0, 1'b1, S_Z4);
      drive(1'b0, 1'b1, 1'b0, 1'b1, S_Z0);
      drive(1'b1, 1'b1, 1'b0, 1'b1, S_Z0);
      run_seq(32'b00001, 32'b00001, 5);

      // drain the scoreboard with a bounded wait
      wait_cycles = 0;
      while (exp_q.size() > 0 && wait_cycles < 10) begin
         @(negedge clock);
         wait_cycles++;
      end
      @(negedge clock);
      if (exp_q.size() > 0) begin
         bad++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
